// File: rtl/dmem_arbiter_if.sv
// Port bundle for the two-requester data memory arbiter.
// Carries both requester ports, the memory side and the debug owner.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [1:0]    owner;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_dout,
    output gnt0, gnt1, rdata0, rdata1,
    output rvalid0, rvalid1,
    output mem_read, mem_write, mem_addr, mem_din,
    output owner
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_dout,
    input  gnt0, gnt1, rdata0, rdata1,
    input  rvalid0, rvalid1,
    input  mem_read, mem_write, mem_addr, mem_din,
    input  owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one 256x8 data memory
// between the core load/store port (0) and the loader/DMA port (1).
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave bus
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state, state_nx;
  logic          last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          g0, g1;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1;
  logic          mrd, mwr;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdin;

  always_comb begin
    state_nx = state;
    last_nx  = last;
    cnt_nx   = cnt;
    g0       = 1'b0;
    g1       = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (bus.req0 && bus.req1)
          state_nx = last ? OWN0 : OWN1;
        else if (bus.req0)
          state_nx = OWN0;
        else if (bus.req1)
          state_nx = OWN1;
      end
      OWN0: begin
        g0 = bus.req0;
        if (g0) last_nx = 1'b0;
        if (!bus.req0) begin
          state_nx = bus.req1 ? OWN1 : IDLE;
          cnt_nx   = '0;
        end else if (bus.req1 && cnt == CMAX) begin
          state_nx = OWN1;
          cnt_nx   = '0;
        end else if (cnt != CMAX) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      OWN1: begin
        g1 = bus.req1;
        if (g1) last_nx = 1'b1;
        if (!bus.req1) begin
          state_nx = bus.req0 ? OWN0 : IDLE;
          cnt_nx   = '0;
        end else if (bus.req0 && cnt == CMAX) begin
          state_nx = OWN0;
          cnt_nx   = '0;
        end else if (cnt != CMAX) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Grants are forced low the instant reset rises, killing any in-flight write.
  assign gnt0 = g0 & ~reset;
  assign gnt1 = g1 & ~reset;

  always_comb begin
    mrd   = 1'b0;
    mwr   = 1'b0;
    maddr = '0;
    mdin  = '0;
    unique case (1'b1)
      gnt0: begin
        mrd   = ~bus.we0;
        mwr   = bus.we0;
        maddr = bus.addr0;
        mdin  = bus.wdata0;
      end
      gnt1: begin
        mrd   = ~bus.we1;
        mwr   = bus.we1;
        maddr = bus.addr1;
        mdin  = bus.wdata1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      last    <= 1'b1;
      cnt     <= '0;
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state   <= state_nx;
      last    <= last_nx;
      cnt     <= cnt_nx;
      rvalid0 <= gnt0 & ~bus.we0;
      rvalid1 <= gnt1 & ~bus.we1;
      if (gnt0 && !bus.we0) rdata0 <= bus.mem_dout;
      if (gnt1 && !bus.we1) rdata1 <= bus.mem_dout;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.rdata0    = rdata0;
  assign bus.rdata1    = rdata1;
  assign bus.rvalid0   = rvalid0;
  assign bus.rvalid1   = rvalid1;
  assign bus.mem_read  = mrd;
  assign bus.mem_write = mwr;
  assign bus.mem_addr  = maddr;
  assign bus.mem_din   = mdin;
  assign bus.owner     = reset ? 2'b00 : state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations,
// then random traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(8), .DW(8)) ifc ();

  dmem_arbiter #(.AW(8), .DW(8), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (ifc.slave)
  );

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       init_en = 1'b0;

  assign ifc.mem_dout = mem[ifc.mem_addr];

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (ifc.mem_write) begin
      mem[ifc.mem_addr] <= ifc.mem_din;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: owner index, grants in current tenure, last served.
  logic       model_on = 1'b0;
  int         own, run, lastp;
  logic [7:0] shadow [256];
  logic [7:0] rde [2];
  logic       rve [2];
  logic       m_rq [2];
  logic       m_we [2];
  logic [7:0] m_ad [2];
  logic [7:0] m_wd [2];
  logic       eg [2];
  logic       erd, ewr;
  logic [7:0] ead, edin;
  int         q;

  always @(negedge clk) begin
    if (model_on) begin
      if (rst) begin
        chk("rst_gnt0", 32'(ifc.gnt0), 0);
        chk("rst_gnt1", 32'(ifc.gnt1), 0);
        chk("rst_mrd", 32'(ifc.mem_read), 0);
        chk("rst_mwr", 32'(ifc.mem_write), 0);
        chk("rst_owner", 32'(ifc.owner), 0);
        chk("rst_rv0", 32'(ifc.rvalid0), 0);
        chk("rst_rv1", 32'(ifc.rvalid1), 0);
        chk("rst_rd0", 32'(ifc.rdata0), 0);
        chk("rst_rd1", 32'(ifc.rdata1), 0);
        own = -1; run = 0; lastp = 1;
        rve[0] = 0; rve[1] = 0; rde[0] = 0; rde[1] = 0;
      end else begin
        m_rq[0] = ifc.req0;   m_rq[1] = ifc.req1;
        m_we[0] = ifc.we0;    m_we[1] = ifc.we1;
        m_ad[0] = ifc.addr0;  m_ad[1] = ifc.addr1;
        m_wd[0] = ifc.wdata0; m_wd[1] = ifc.wdata1;
        erd = 0; ewr = 0; ead = 0; edin = 0;
        for (int p = 0; p < 2; p++) begin
          eg[p] = (own == p) && m_rq[p];
          if (eg[p]) begin
            erd = !m_we[p]; ewr = m_we[p];
            ead = m_ad[p];  edin = m_wd[p];
          end
        end
        chk("gnt0", 32'(ifc.gnt0), 32'(eg[0]));
        chk("gnt1", 32'(ifc.gnt1), 32'(eg[1]));
        chk("owner", 32'(ifc.owner), own < 0 ? 0 : own + 1);
        chk("mem_read", 32'(ifc.mem_read), 32'(erd));
        chk("mem_write", 32'(ifc.mem_write), 32'(ewr));
        if (eg[0] || eg[1]) begin
          chk("mem_addr", 32'(ifc.mem_addr), 32'(ead));
          if (ewr) chk("mem_din", 32'(ifc.mem_din), 32'(edin));
        end
        chk("rvalid0", 32'(ifc.rvalid0), 32'(rve[0]));
        chk("rvalid1", 32'(ifc.rvalid1), 32'(rve[1]));
        chk("rdata0", 32'(ifc.rdata0), 32'(rde[0]));
        chk("rdata1", 32'(ifc.rdata1), 32'(rde[1]));
        for (int p = 0; p < 2; p++) begin
          rve[p] = 0;
          if (eg[p]) begin
            lastp = p;
            if (m_we[p]) shadow[m_ad[p]] = m_wd[p];
            else begin
              rde[p] = shadow[m_ad[p]];
              rve[p] = 1;
            end
          end
        end
        if (own < 0) begin
          run = 0;
          if (m_rq[0] && m_rq[1]) own = 1 - lastp;
          else if (m_rq[0]) own = 0;
          else if (m_rq[1]) own = 1;
        end else begin
          q = 1 - own;
          if (!m_rq[own]) begin
            own = m_rq[q] ? q : -1;
            run = 0;
          end else if (m_rq[q] && run >= MB - 1) begin
            own = q;
            run = 0;
          end else begin
            run++;
          end
        end
      end
    end
  end

  logic       rq_s [2];
  logic       we_s [2];
  logic [7:0] ad_s [2];
  logic [7:0] wd_s [2];
  logic       gs [2];

  task automatic put();
    ifc.req0 = rq_s[0]; ifc.we0 = we_s[0];
    ifc.addr0 = ad_s[0]; ifc.wdata0 = wd_s[0];
    ifc.req1 = rq_s[1]; ifc.we1 = we_s[1];
    ifc.addr1 = ad_s[1]; ifc.wdata1 = wd_s[1];
  endtask

  task automatic fresh(input int p);
    rq_s[p] = 1;
    we_s[p] = 1'($urandom_range(0, 1));
    ad_s[p] = 8'($urandom_range(0, 15));
    wd_s[p] = 8'($urandom);
  endtask

  int pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[8'h10] = 8'h5A;
    for (int p = 0; p < 2; p++) begin
      rq_s[p] = 0; we_s[p] = 0; ad_s[p] = 0; wd_s[p] = 0;
    end
    put();
    init_en = 1'b1;
    #2;
    chk("t0_owner", 32'(ifc.owner), 0);
    chk("t0_gnt", 32'({ifc.gnt1, ifc.gnt0}), 0);
    chk("t0_rvalid", 32'({ifc.rvalid1, ifc.rvalid0}), 0);
    chk("t0_rdata", 32'({ifc.rdata1, ifc.rdata0}), 0);
    cyc();
    init_en = 1'b0;
    rst = 1'b0;

    // single read
    cyc();
    ifc.req0 = 1; ifc.we0 = 0; ifc.addr0 = 8'h10;
    #1 chk("t2_idle_gnt0", 32'(ifc.gnt0), 0);
    cyc();
    chk("t2_owner", 32'(ifc.owner), 1);
    chk("t2_gnt0", 32'(ifc.gnt0), 1);
    chk("t2_mrd", 32'(ifc.mem_read), 1);
    chk("t2_maddr", 32'(ifc.mem_addr), 32'h10);
    cyc();
    ifc.req0 = 0;
    chk("t2_rvalid0", 32'(ifc.rvalid0), 1);
    chk("t2_rdata0", 32'(ifc.rdata0), 32'h5A);
    cyc();
    chk("t2_rvalid0_off", 32'(ifc.rvalid0), 0);
    chk("t2_owner_idle", 32'(ifc.owner), 0);

    // reset mid write
    ifc.req1 = 1; ifc.we1 = 1; ifc.addr1 = 8'h20; ifc.wdata1 = 8'h77;
    cyc();
    chk("t1_gnt1", 32'(ifc.gnt1), 1);
    chk("t1_mwr", 32'(ifc.mem_write), 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_mwr_drop", 32'(ifc.mem_write), 0);
    chk("t1_gnt1_drop", 32'(ifc.gnt1), 0);
    chk("t1_owner", 32'(ifc.owner), 0);
    chk("t1_rdata0", 32'(ifc.rdata0), 0);
    cyc();
    ifc.req1 = 0;
    chk("t1_lost_write", 32'(mem[8'h20]), 0);
    rst = 1'b0;

    // ties from idle
    cyc();
    ifc.req0 = 1; ifc.we0 = 0; ifc.addr0 = 8'h01;
    ifc.req1 = 1; ifc.we1 = 0; ifc.addr1 = 8'h02;
    cyc();
    chk("t3_tie1_gnt", 32'({ifc.gnt1, ifc.gnt0}), 32'b01);
    cyc();
    ifc.req0 = 0; ifc.req1 = 0;
    cyc();
    chk("t3_idle", 32'(ifc.owner), 0);
    ifc.req0 = 1; ifc.req1 = 1;
    cyc();
    chk("t3_tie2_gnt", 32'({ifc.gnt1, ifc.gnt0}), 32'b10);
    chk("t3_tie2_owner", 32'(ifc.owner), 2);
    cyc();
    ifc.req0 = 0; ifc.req1 = 0;
    cyc();

    // burst fairness
    ifc.req0 = 1; ifc.addr0 = 8'h03;
    ifc.req1 = 1; ifc.addr1 = 8'h04;
    cyc();
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t4_gnt0_%0d", i), 32'(ifc.gnt0), 32'(pat[i] == 0));
      chk($sformatf("t4_gnt1_%0d", i), 32'(ifc.gnt1), 32'(pat[i] == 1));
      cyc();
    end
    ifc.req0 = 0; ifc.req1 = 0;
    cyc();

    // write by port 1, read back by port 0
    ifc.req1 = 1; ifc.we1 = 1; ifc.addr1 = 8'hFF; ifc.wdata1 = 8'hC3;
    cyc();
    chk("t5_gnt1", 32'(ifc.gnt1), 1);
    chk("t5_mdin", 32'(ifc.mem_din), 32'hC3);
    cyc();
    ifc.req1 = 0;
    ifc.req0 = 1; ifc.we0 = 0; ifc.addr0 = 8'hFF;
    chk("t5_mem", 32'(mem[8'hFF]), 32'hC3);
    cyc();
    chk("t5_gnt0", 32'(ifc.gnt0), 1);
    cyc();
    ifc.req0 = 0;
    chk("t5_rvalid0", 32'(ifc.rvalid0), 1);
    chk("t5_rdata0", 32'(ifc.rdata0), 32'hC3);
    cyc();

    // withdrawn request from port 1
    ifc.req0 = 1; ifc.addr0 = 8'h05;
    cyc();
    ifc.req1 = 1; ifc.we1 = 1; ifc.addr1 = 8'h06; ifc.wdata1 = 8'h11;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) ifc.req1 = 0;
      #1 chk($sformatf("t6_gnt1_%0d", i), 32'(ifc.gnt1), 0);
      chk($sformatf("t6_gnt0_%0d", i), 32'(ifc.gnt0), 1);
      cyc();
    end
    ifc.req0 = 0;
    cyc();
    chk("t6_owner", 32'(ifc.owner), 0);
    chk("t6_nowrite", 32'(mem[8'h06]), 0);

    // random traffic against the model
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      img[i] = 8'($urandom);
      shadow[i] = img[i];
    end
    init_en = 1'b1;
    model_on = 1'b1;
    for (int p = 0; p < 2; p++) rq_s[p] = 0;
    put();
    cyc();
    init_en = 1'b0;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gs[0] = ifc.gnt0; gs[1] = ifc.gnt1;
      cyc();
      if (c == 1500) rst = 1'b1;
      else if (c == 1502) rst = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (rq_s[p] && gs[p]) begin
          if ($urandom_range(0, 9) < 7) fresh(p);
          else rq_s[p] = 0;
        end else if (rq_s[p]) begin
          if ($urandom_range(0, 19) == 0) rq_s[p] = 0;
        end else if ($urandom_range(0, 9) < 4) begin
          fresh(p);
        end
      end
      put();
    end
    @(negedge clk);
    #1 model_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
